othello_move_ctrl: RTL and testbench

//  Sequencer that validates and applies one Othello move against the 10x10 walled board memory.

---
 rtl/othello_move_ctrl_pkg.sv | 28 ++
 rtl/othello_move_ctrl_dir_offset.sv | 20 ++
 rtl/othello_move_ctrl.sv | 154 +++++++++++++++
 tb/tb_othello_move_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/othello_move_ctrl_pkg.sv
// Shared definitions for the Othello move sequencer: cell codes, board limits and FSM states.
package othello_move_ctrl_pkg;

  localparam logic [1:0] CELL_NULL  = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Highest address on the 10x10 walled board.
  localparam logic [6:0] ADDR_LAST = 7'd99;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK_RD,
    S_CHK_EV,
    S_DIR_INIT,
    S_SCAN_RD,
    S_SCAN_EV,
    S_FLIP,
    S_NEXT,
    S_PLACE,
    S_FIN
  } state_e;

  function automatic logic [1:0] own_code(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/othello_move_ctrl_dir_offset.sv
// Direction index to signed board-address step on the 10-wide board.
module othello_move_ctrl_dir_offset (
  input  logic [2:0]        i_dir,
  output logic signed [7:0] o_off
);

  always_comb begin
    case (i_dir)
      3'd0:    o_off = -8'sd11;
      3'd1:    o_off = -8'sd10;
      3'd2:    o_off = -8'sd9;
      3'd3:    o_off = -8'sd1;
      3'd4:    o_off =  8'sd1;
      3'd5:    o_off =  8'sd9;
      3'd6:    o_off =  8'sd10;
      default: o_off =  8'sd11;
    endcase
  end

endmodule

// File: rtl/othello_move_ctrl.sv
// Validates one Othello move by scanning 8 directions over the shared board memory port,
// writes every flipped disc as found, then the placed disc.
module othello_move_ctrl
  import othello_move_ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [6:0] i_move_addr,
  input  logic       i_player,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_move_valid,
  output logic [4:0] o_flip_count,
  output logic [6:0] o_mem_addr,
  output logic [1:0] o_mem_wdata,
  output logic       o_mem_wren,
  output logic       o_mem_rden,
  input  logic [1:0] i_mem_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_RD_LAT - 1);

  state_e            r_state, w_next;
  logic [6:0]        r_base;
  logic [1:0]        r_own;
  logic signed [7:0] r_cur;
  logic [2:0]        r_run;
  logic [2:0]        r_dir;
  logic [1:0]        r_lat;
  logic [4:0]        r_flip;
  logic              r_valid;

  logic signed [7:0] w_off, w_line0;
  logic              w_lat_done, w_is_opp, w_is_own, w_unused;

  othello_move_ctrl_dir_offset u_dir_offset (
    .i_dir (r_dir),
    .o_off (w_off)
  );

  assign w_line0    = $signed({1'b0, r_base}) + w_off;
  assign w_lat_done = (r_lat == LAT_LAST);
  assign w_is_opp   = (i_mem_rdata == ~r_own);
  assign w_is_own   = (i_mem_rdata == r_own);
  // Walls keep scans inside 0..99, so the sign bit of the cursor never reaches memory.
  assign w_unused   = r_cur[7];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_FIN);
    o_mem_rden   = 1'b0;
    o_mem_wren   = 1'b0;
    o_mem_addr   = 7'd0;
    o_mem_wdata  = CELL_NULL;
    o_move_valid = r_valid;
    o_flip_count = r_flip;
    case (r_state)
      S_IDLE:     if (i_start) w_next = (i_move_addr > ADDR_LAST) ? S_FIN : S_CHK_RD;
      S_CHK_RD: begin
        o_mem_rden = (r_lat == 2'd0);
        o_mem_addr = r_base;
        if (w_lat_done) w_next = S_CHK_EV;
      end
      // Any non-null cell (including wall) rejects the move.
      S_CHK_EV:   w_next = (i_mem_rdata != CELL_NULL) ? S_FIN : S_DIR_INIT;
      S_DIR_INIT: w_next = S_SCAN_RD;
      S_SCAN_RD: begin
        o_mem_rden = (r_lat == 2'd0);
        o_mem_addr = r_cur[6:0];
        if (w_lat_done) w_next = S_SCAN_EV;
      end
      S_SCAN_EV: begin
        if (w_is_opp)                      w_next = S_SCAN_RD;
        else if (w_is_own && r_run != '0)  w_next = S_FLIP;
        else                               w_next = S_NEXT;
      end
      S_FLIP: begin
        o_mem_wren  = 1'b1;
        o_mem_addr  = r_cur[6:0];
        o_mem_wdata = r_own;
        if (r_run == 3'd1) w_next = S_NEXT;
      end
      S_NEXT: begin
        if (r_dir == 3'd7) w_next = (r_flip != '0) ? S_PLACE : S_FIN;
        else               w_next = S_DIR_INIT;
      end
      S_PLACE: begin
        o_mem_wren  = 1'b1;
        o_mem_addr  = r_base;
        o_mem_wdata = r_own;
        w_next      = S_FIN;
      end
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base  <= '0;
      r_own   <= CELL_NULL;
      r_cur   <= '0;
      r_run   <= '0;
      r_dir   <= '0;
      r_lat   <= '0;
      r_flip  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_lat <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base  <= i_move_addr;
            r_own   <= own_code(i_player);
            r_dir   <= '0;
            r_flip  <= '0;
            r_valid <= 1'b0;
          end
        end
        S_CHK_RD, S_SCAN_RD: if (!w_lat_done) r_lat <= r_lat + 2'd1;
        S_DIR_INIT: begin
          r_cur <= w_line0;
          r_run <= '0;
        end
        S_SCAN_EV: begin
          if (w_is_opp) begin
            r_run <= r_run + 3'd1;
            r_cur <= r_cur + w_off;
          end else if (w_is_own && r_run != '0) begin
            r_cur <= w_line0;
          end
        end
        S_FLIP: begin
          r_cur  <= r_cur + w_off;
          r_run  <= r_run - 3'd1;
          r_flip <= r_flip + 5'd1;
        end
        S_NEXT:  if (r_dir != 3'd7) r_dir <= r_dir + 3'd1;
        S_PLACE: r_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_othello_move_ctrl.sv
// Runs identical moves on three instances (read latency 1, 2, 3) against a board-level move model.
module tb_othello_move_ctrl;
  localparam int NI = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, player = 1'b0, load = 1'b0;
  logic [6:0] move_addr = '0;
  logic [NI-1:0] busy, done, valid, wren, rden;
  logic [NI-1:0][4:0] fc;
  logic [NI-1:0][6:0] maddr;
  logic [NI-1:0][1:0] wdata, rdata;
  int total = 0, bad = 0;

  logic [1:0] board_img [0:99];
  int         exp_n = 0, exp_fc = 0;
  logic [6:0] exp_a [0:31];
  logic [1:0] exp_d [0:31];
  logic       exp_valid = 1'b0, exp_noacc = 1'b0;
  int         wptr [NI];
  int         ndone [NI];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    logic [1:0] mem [0:127];
    logic [1:0] rpipe [0:2];

    othello_move_ctrl #(.MEM_RD_LAT(gi + 1)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_move_addr(move_addr),
      .i_player(player), .o_busy(busy[gi]), .o_done(done[gi]), .o_move_valid(valid[gi]),
      .o_flip_count(fc[gi]), .o_mem_addr(maddr[gi]), .o_mem_wdata(wdata[gi]),
      .o_mem_wren(wren[gi]), .o_mem_rden(rden[gi]), .i_mem_rdata(rdata[gi])
    );

    assign rdata[gi] = rpipe[gi];

    // Board memory: data appears gi+1 cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
      if (load) for (int k = 0; k < 100; k++) mem[k] <= board_img[k];
      else if (wren[gi]) mem[maddr[gi]] <= wdata[gi];
      rpipe[0] <= rden[gi] ? mem[maddr[gi]] : 2'($urandom);
      rpipe[1] <= rpipe[0];
      rpipe[2] <= rpipe[1];
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (start && !busy[gi]) wptr[gi] = 0;
        chk($sformatf("rd_wr_overlap%0d", gi), int'(rden[gi] & wren[gi]), 0);
        chk($sformatf("no_access%0d", gi), int'((rden[gi] | wren[gi]) & exp_noacc), 0);
        if (rden[gi]) chk($sformatf("rd_addr_range%0d", gi), int'(maddr[gi] <= 7'd99), 1);
        if (!wren[gi]) chk($sformatf("wdata_idle%0d", gi), int'(wdata[gi]), 0);
        else begin
          if (wptr[gi] < exp_n) begin
            chk($sformatf("wr_addr%0d_%0d", gi, wptr[gi]), int'(maddr[gi]), int'(exp_a[wptr[gi]]));
            chk($sformatf("wr_data%0d_%0d", gi, wptr[gi]), int'(wdata[gi]), int'(exp_d[wptr[gi]]));
          end else chk($sformatf("extra_write%0d", gi), wptr[gi], exp_n - 1);
          wptr[gi] = wptr[gi] + 1;
        end
        if (done[gi]) begin
          chk($sformatf("done_valid%0d", gi), int'(valid[gi]), int'(exp_valid));
          chk($sformatf("done_fc%0d", gi), int'(fc[gi]), exp_fc);
          chk($sformatf("write_count%0d", gi), wptr[gi], exp_n);
          ndone[gi] = ndone[gi] + 1;
        end
      end
    end
  end

  // Reference: walk each direction over the pre-move board, near to far, in direction order.
  task automatic model(input int base, input logic pl);
    int off [8];
    int k;
    logic [1:0] own, opp;
    off = '{-11, -10, -9, -1, 1, 9, 10, 11};
    own = pl ? 2'b10 : 2'b01;
    opp = ~own;
    exp_n = 0; exp_fc = 0; exp_valid = 1'b0;
    exp_noacc = (base > 99);
    if (base > 99) return;
    if (board_img[base] != 2'b00) return;
    for (int d = 0; d < 8; d++) begin
      k = 1;
      while (board_img[base + k * off[d]] == opp) k++;
      if (k > 1 && board_img[base + k * off[d]] == own)
        for (int j = 1; j < k; j++) begin
          exp_a[exp_n] = 7'(base + j * off[d]);
          exp_d[exp_n] = own;
          exp_n++;
        end
    end
    exp_fc = exp_n;
    if (exp_n > 0) begin
      exp_a[exp_n] = 7'(base);
      exp_d[exp_n] = own;
      exp_n++;
      exp_valid = 1'b1;
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 100; i++)
      board_img[i] = (i < 10 || i > 89 || i % 10 == 0 || i % 10 == 9) ? 2'b11 : 2'b00;
  endtask

  task automatic load_board();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic run_move(input string nm, input int base, input logic pl, input bit poke);
    int  d0 [NI];
    int  cyc;
    bit  all;
    model(base, pl);
    for (int i = 0; i < NI; i++) d0[i] = ndone[i];
    @(posedge clk); #1 move_addr = 7'(base); player = pl; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "_busy"}, int'(busy), 7);
    if (poke && base <= 99) begin
      @(posedge clk);
      @(posedge clk); #1 start = 1'b1; move_addr = 7'd0; player = ~pl;
      @(posedge clk); #1 start = 1'b0;
    end
    cyc = 0; all = 1'b0;
    while (!all && cyc < 400) begin
      @(posedge clk);
      cyc++;
      all = 1'b1;
      for (int i = 0; i < NI; i++) if (ndone[i] == d0[i]) all = 1'b0;
    end
    chk({nm, "_finished"}, int'(all), 1);
    #1;
    chk({nm, "_idle_busy"}, int'(busy), 0);
    chk({nm, "_held_valid"}, int'(valid), exp_valid ? 7 : 0);
    for (int i = 0; i < NI; i++) chk({nm, "_held_fc"}, int'(fc[i]), exp_fc);
  endtask

  initial begin
    int cyc, r, base;
    for (int i = 0; i < NI; i++) begin wptr[i] = 0; ndone[i] = 0; end
    clear_board();
    repeat (3) @(posedge clk);
    #1 chk("rst_outputs", int'(|{busy, done, valid, wren, rden, fc, maddr, wdata}), 0);
    #2 rst_n = 1'b1;

    // 1: single flip along +1
    clear_board();
    board_img[44] = 2'b10; board_img[55] = 2'b10; board_img[45] = 2'b01; board_img[54] = 2'b01;
    load_board();
    run_move("t1", 43, 1'b0, 1'b0);
    chk("t1_model_fc", exp_fc, 1);
    chk("t1_dut_fc", int'(fc[0]), 1);
    chk("t1_dut_valid", int'(valid[2]), 1);

    // 2: occupied target
    load_board();
    run_move("t2", 44, 1'b0, 1'b1);
    chk("t2_dut_valid", int'(valid[1]), 0);
    chk("t2_model_writes", exp_n, 0);

    // 3: six flips ending at the own disc before the wall
    clear_board();
    for (int i = 12; i <= 17; i++) board_img[i] = 2'b10;
    board_img[18] = 2'b01;
    load_board();
    run_move("t3", 11, 1'b0, 1'b1);
    chk("t3_dut_fc", int'(fc[2]), 6);
    chk("t3_model_last", int'(exp_a[exp_n - 1]), 11);

    // 4: opponents with no closing disc
    clear_board();
    board_img[45] = 2'b10; board_img[47] = 2'b10; board_img[36] = 2'b10; board_img[56] = 2'b10;
    load_board();
    run_move("t4", 46, 1'b0, 1'b0);
    chk("t4_dut_valid", int'(valid[0]), 0);

    // 5: two directions
    clear_board();
    board_img[44] = 2'b10; board_img[55] = 2'b01; board_img[34] = 2'b10; board_img[35] = 2'b01;
    load_board();
    run_move("t5", 33, 1'b0, 1'b1);
    chk("t5_dut_fc", int'(fc[1]), 2);
    chk("t5_model_first", int'(exp_a[0]), 34);

    // out-of-range address: immediate invalid, no access
    run_move("t_oob", 120, 1'b1, 1'b0);
    chk("t_oob_valid", int'(valid[0]), 0);

    // reset while the latency-1 instance is flipping
    clear_board();
    for (int i = 12; i <= 17; i++) board_img[i] = 2'b10;
    board_img[18] = 2'b01;
    load_board();
    model(11, 1'b0);
    @(posedge clk); #1 move_addr = 7'd11; player = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!wren[0] && cyc < 300) begin @(negedge clk); cyc++; end
    chk("reached_flip", int'(wren[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", int'(|{busy, done, valid, wren, rden, fc, maddr, wdata}), 0);
    @(negedge clk); rst_n = 1'b1;
    clear_board();
    board_img[44] = 2'b01; board_img[45] = 2'b01; board_img[46] = 2'b10;
    load_board();
    run_move("t_after_rst", 43, 1'b1, 1'b0);
    chk("t_after_rst_fc", int'(fc[0]), 2);

    // random boards and moves
    for (int t = 0; t < 60; t++) begin
      clear_board();
      for (int rr = 1; rr <= 8; rr++)
        for (int cc = 1; cc <= 8; cc++) begin
          r = int'($urandom_range(0, 9));
          board_img[rr * 10 + cc] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
        end
      if ($urandom_range(0, 7) == 0) base = int'($urandom_range(0, 127));
      else begin
        base = 11 + 10 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 7) board_img[base] = 2'b00;
      end
      load_board();
      run_move($sformatf("rnd%0d", t), base, 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
